// File: rtl/score_keeper.sv
// Two-player score keeper: edge-detected point inputs, saturating scores, PLAY/OVER FSM
// and a free-running digit-select refresh for a two-digit seven-segment display.
module score_keeper #(
  parameter int REFRESH_DIV = 100000,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_p0,
  input  logic       point_p1,
  input  logic       new_game,
  output logic [3:0] num_0,
  output logic [3:0] num_1,
  output logic       count,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic {PLAY, OVER} state_t;

  localparam logic [3:0]  WIN          = 4'(WIN_SCORE);
  localparam logic [19:0] REFRESH_LAST = 20'(REFRESH_DIV - 1);

  state_t      state;
  logic        prev_0;
  logic        prev_1;
  logic [19:0] refresh_cnt;
  logic        hit_0;
  logic        hit_1;
  logic [3:0]  next_0;
  logic [3:0]  next_1;
  logic        reach_0;
  logic        reach_1;

  // Increment only on an event and never past the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] num, input logic hit);
    if (hit && (num < WIN))
      return num + 4'd1;
    return num;
  endfunction

  always_comb begin
    hit_0   = point_p0 & ~prev_0;
    hit_1   = point_p1 & ~prev_1;
    next_0  = sat_inc(num_0, hit_0);
    next_1  = sat_inc(num_1, hit_1);
    reach_0 = (next_0 == WIN);
    reach_1 = (next_1 == WIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PLAY;
      prev_0      <= 1'b1;
      prev_1      <= 1'b1;
      refresh_cnt <= '0;
      count       <= 1'b0;
      num_0       <= '0;
      num_1       <= '0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      prev_0 <= point_p0;
      prev_1 <= point_p1;

      // Display refresh runs independently of the game state.
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        count       <= ~count;
      end else begin
        refresh_cnt <= refresh_cnt + 20'd1;
      end

      if (new_game) begin
        state     <= PLAY;
        num_0     <= '0;
        num_1     <= '0;
        game_over <= 1'b0;
        winner    <= 2'b00;
      end else begin
        case (state)
          PLAY: begin
            num_0 <= next_0;
            num_1 <= next_1;
            if (reach_0 || reach_1) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= {reach_1, reach_0};
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: state <= PLAY;
        endcase
      end
    end
  end

endmodule
